// File: rtl/fp_pkg.sv
// Shared binary32 constants and the unpacked-operand record used by the
// FP adder front end (fp_align_stage and fp_align_shifter).
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int MANT_W   = MAN_W + 1;
    localparam int EXP_BIAS = 127;
    localparam int SHIFT_W  = 5;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [EXP_W-1:0]  effexp;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;

    // Denormals behave as if their exponent were 1 and have no hidden bit.
    function automatic fp_unpacked_t fp_unpack(input logic [EXP_W+MAN_W:0] word);
        fp_unpacked_t u;
        logic         is_denorm;
        is_denorm = (word[EXP_W+MAN_W-1:MAN_W] == '0);
        u.sign    = word[EXP_W+MAN_W];
        u.exp     = word[EXP_W+MAN_W-1:MAN_W];
        u.effexp  = is_denorm ? EXP_W'(1) : word[EXP_W+MAN_W-1:MAN_W];
        u.mant    = {~is_denorm, word[MAN_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational 24-bit logarithmic right shifter with sticky collection.
// Amounts of 24 or more produce zero; sticky is the OR of every bit dropped.
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0]  mant,
    input  logic [SHIFT_W-1:0] amount,
    output logic [MANT_W-1:0]  shifted,
    output logic               sticky
);

    always_comb begin
        logic [MANT_W-1:0] cur;
        logic              lost;
        // NOTE: every variable gets a value before any conditional path, so no latch can be inferred.
        cur  = mant;
        lost = 1'b0;
        // Levels of 1,2,4,8,16 add up to 31, so any amount >= 24 empties the word.
        for (int i = 0; i < SHIFT_W; i++) begin
            if (amount[i]) begin
                lost = lost | (|(cur & ((MANT_W'(1) << (1 << i)) - MANT_W'(1))));
                cur  = cur >> (1 << i);
            end
        end
        shifted = cur;
        sticky  = lost;
    end

endmodule

// File: rtl/fp_align_stage.sv
// Three-stage binary32 alignment front end: unpack, order by magnitude, align.
// Optional STICKY output enabled by defining FP_ALIGN_STICKY_EN.
module fp_align_stage
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    output logic                out_valid,
    output logic                SIGN_A,
    output logic [MANT_W-1:0]   MANTISSA_A,
    output logic                SIGN_B,
    output logic [MANT_W-1:0]   MANTISSA_B,
    output logic [EXP_W-1:0]    EXPONENT,
    output logic                SAME_SIGN,
    output logic                SPECIAL
`ifdef FP_ALIGN_STICKY_EN
    ,
    output logic                STICKY
`endif
);

    // ---------------- stage 1: unpack ----------------
    fp_unpacked_t     in_a, in_b;
    logic             s1_valid;
    fp_unpacked_t     s1_a, s1_b;
    logic [EXP_W:0]   s1_diff_ab, s1_diff_ba;

    assign in_a = fp_unpack(A);
    assign in_b = fp_unpack(B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_diff_ab <= '0;
            s1_diff_ba <= '0;
        end else begin
            // NOTE: non-blocking assignments keep each stage reading the previous cycle's values.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a       <= in_a;
                s1_b       <= in_b;
                s1_diff_ab <= {1'b0, in_a.effexp} - {1'b0, in_b.effexp};
                s1_diff_ba <= {1'b0, in_b.effexp} - {1'b0, in_a.effexp};
            end
        end
    end

    // ---------------- stage 2: order ----------------
    logic               a_larger;
    logic [EXP_W:0]     abs_diff;
    logic [SHIFT_W-1:0] shift_sat;

    always_comb begin
        a_larger  = (s1_a.effexp > s1_b.effexp) ||
                    ((s1_a.effexp == s1_b.effexp) && (s1_a.mant >= s1_b.mant));
        abs_diff  = a_larger ? s1_diff_ab : s1_diff_ba;
        shift_sat = (abs_diff > (EXP_W+1)'(31)) ? '1 : abs_diff[SHIFT_W-1:0];
    end

    logic               s2_valid;
    logic               s2_sign_a, s2_sign_b;
    logic [MANT_W-1:0]  s2_mant_a, s2_mant_b;
    logic [EXP_W-1:0]   s2_exp;
    logic [SHIFT_W-1:0] s2_shift;
    logic               s2_special, s2_same_sign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            s2_sign_a    <= 1'b0;
            s2_sign_b    <= 1'b0;
            s2_mant_a    <= '0;
            s2_mant_b    <= '0;
            s2_exp       <= '0;
            s2_shift     <= '0;
            s2_special   <= 1'b0;
            s2_same_sign <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign_a    <= a_larger ? s1_a.sign : s1_b.sign;
                s2_mant_a    <= a_larger ? s1_a.mant : s1_b.mant;
                s2_exp       <= a_larger ? s1_a.exp  : s1_b.exp;
                s2_sign_b    <= a_larger ? s1_b.sign : s1_a.sign;
                s2_mant_b    <= a_larger ? s1_b.mant : s1_a.mant;
                s2_shift     <= shift_sat;
                s2_special   <= (s1_a.exp == EXP_SPECIAL) || (s1_b.exp == EXP_SPECIAL);
                s2_same_sign <= (s1_a.sign == s1_b.sign);
            end
        end
    end

    // ---------------- stage 3: align ----------------
    logic [MANT_W-1:0] aligned_b;
`ifdef FP_ALIGN_STICKY_EN
    logic              shift_sticky;
`else
    logic              shift_sticky_unused;
`endif

    fp_align_shifter u_shifter (
        .mant    (s2_mant_b),
        .amount  (s2_shift),
        .shifted (aligned_b),
`ifdef FP_ALIGN_STICKY_EN
        .sticky  (shift_sticky)
`else
        .sticky  (shift_sticky_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            SIGN_A     <= 1'b0;
            MANTISSA_A <= '0;
            SIGN_B     <= 1'b0;
            MANTISSA_B <= '0;
            EXPONENT   <= '0;
            SAME_SIGN  <= 1'b0;
            SPECIAL    <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
            STICKY     <= 1'b0;
`endif
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                SIGN_A     <= s2_sign_a;
                MANTISSA_A <= s2_mant_a;
                SIGN_B     <= s2_sign_b;
                MANTISSA_B <= aligned_b;
                EXPONENT   <= s2_exp;
                SAME_SIGN  <= s2_same_sign;
                SPECIAL    <= s2_special;
`ifdef FP_ALIGN_STICKY_EN
                STICKY     <= shift_sticky;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed cases, reset mid-stream and
// a randomized stream compared against a magnitude-ordering reference model.
`timescale 1ns/1ps
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] A, B;
    logic        out_valid, SIGN_A, SIGN_B, SAME_SIGN, SPECIAL;
    logic [23:0] MANTISSA_A, MANTISSA_B;
    logic [7:0]  EXPONENT;
`ifdef FP_ALIGN_STICKY_EN
    logic        STICKY;
`endif

    fp_align_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .SIGN_A     (SIGN_A),
        .MANTISSA_A (MANTISSA_A),
        .SIGN_B     (SIGN_B),
        .MANTISSA_B (MANTISSA_B),
        .EXPONENT   (EXPONENT),
        .SAME_SIGN  (SAME_SIGN),
        .SPECIAL    (SPECIAL)
`ifdef FP_ALIGN_STICKY_EN
        ,
        .STICKY     (STICKY)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          sa;
        int unsigned ma;
        bit          sb;
        int unsigned mb;
        int unsigned e;
        bit          same;
        bit          spec;
        bit          sticky;
    } res_t;

    res_t pipe[$];
    res_t held;
    bit   exp_valid;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: order operands by the (effective exponent, mantissa) key, then divide.
    function automatic res_t ref_model(input bit v, input logic [31:0] a, input logic [31:0] b);
        res_t            r;
        int unsigned     ea, eb, ma, mb, sh, small_m;
        longint unsigned ka, kb;
        ea = (a[30:23] == 0) ? 1 : a[30:23];
        eb = (b[30:23] == 0) ? 1 : b[30:23];
        ma = ((a[30:23] != 0) ? (1 << 23) : 0) + a[22:0];
        mb = ((b[30:23] != 0) ? (1 << 23) : 0) + b[22:0];
        ka = longint'(ea) * (64'd1 << 24) + ma;
        kb = longint'(eb) * (64'd1 << 24) + mb;
        r.v = v;
        if (ka >= kb) begin
            r.sa = a[31]; r.ma = ma; r.e = a[30:23]; r.sb = b[31]; small_m = mb;
            sh = ea - eb;
        end else begin
            r.sa = b[31]; r.ma = mb; r.e = b[30:23]; r.sb = a[31]; small_m = ma;
            sh = eb - ea;
        end
        if (sh > 31) sh = 31;
        r.mb     = small_m >> sh;
        r.sticky = (longint'(small_m) & ((64'd1 << sh) - 1)) != 0;
        r.same   = (a[31] == b[31]);
        r.spec   = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        return r;
    endfunction

    task automatic check_outputs();
        check("out_valid",  {31'b0, out_valid}, {31'b0, exp_valid});
        check("SIGN_A",     {31'b0, SIGN_A},    {31'b0, held.sa});
        check("MANTISSA_A", {8'b0, MANTISSA_A}, held.ma);
        check("SIGN_B",     {31'b0, SIGN_B},    {31'b0, held.sb});
        check("MANTISSA_B", {8'b0, MANTISSA_B}, held.mb);
        check("EXPONENT",   {24'b0, EXPONENT},  held.e);
        check("SAME_SIGN",  {31'b0, SAME_SIGN}, {31'b0, held.same});
        check("SPECIAL",    {31'b0, SPECIAL},   {31'b0, held.spec});
`ifdef FP_ALIGN_STICKY_EN
        check("STICKY",     {31'b0, STICKY},    {31'b0, held.sticky});
`endif
    endtask

    task automatic model_reset();
        res_t z;
        z = '{default: 0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        held      = z;
        exp_valid = 1'b0;
    endtask

    // Drive one cycle from the falling edge, advance the model at the rising edge,
    // and compare on the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b);
        res_t e;
        in_valid = v;
        A = a;
        B = b;
        @(posedge clk);
        pipe.push_back(ref_model(v, a, b));
        e = pipe.pop_front();
        exp_valid = e.v;
        if (e.v) held = e;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] rand_fp(input logic [7:0] base);
        int unsigned m;
        logic [7:0]  e;
        logic [22:0] f;
        m = $urandom_range(0, 7);
        case (m)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3, 4: e = base + 8'($urandom_range(0, 30));
            default: e = 8'($urandom);
        endcase
        f = ($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    logic [31:0] dir_a  [7] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h4B800000,
                                32'h00000001, 32'hBF800000, 32'h80000000};
    logic [31:0] dir_b  [7] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                                32'h00800000, 32'h7F800000, 32'h00000000};
    logic [23:0] dir_ma [7] = '{24'h800000, 24'hC00000, 24'hC00000, 24'h800000,
                                24'h800000, 24'h800000, 24'h000000};
    logic [23:0] dir_mb [7] = '{24'h800000, 24'h400000, 24'h400000, 24'h000000,
                                24'h000001, 24'h000000, 24'h000000};
    logic [7:0]  dir_e  [7] = '{8'h7F, 8'h80, 8'h80, 8'h97, 8'h01, 8'hFF, 8'h00};
    bit          dir_sp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit          dir_ss [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Directed cases with hard-coded results; outputs hold after out_valid drops.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, dir_a[i], dir_b[i]);
            idle(3);
            check($sformatf("dir%0d_MANTISSA_A", i), {8'b0, MANTISSA_A}, {8'b0, dir_ma[i]});
            check($sformatf("dir%0d_MANTISSA_B", i), {8'b0, MANTISSA_B}, {8'b0, dir_mb[i]});
            check($sformatf("dir%0d_EXPONENT", i),   {24'b0, EXPONENT},  {24'b0, dir_e[i]});
            check($sformatf("dir%0d_SPECIAL", i),    {31'b0, SPECIAL},   {31'b0, dir_sp[i]});
            check($sformatf("dir%0d_SAME_SIGN", i),  {31'b0, SAME_SIGN}, {31'b0, dir_ss[i]});
        end
`ifdef FP_ALIGN_STICKY_EN
        cycle(1'b1, 32'h4B800000, 32'h3F800000);
        idle(3);
        check("dir_STICKY_diff24", {31'b0, STICKY}, 32'd1);
`endif

        // Five back-to-back pairs, a one-cycle gap, then drain.
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_fp(8'd100), rand_fp(8'd100));
        cycle(1'b0, $urandom, $urandom);
        idle(4);

        // Reset one cycle after issuing two pairs; those pairs must never appear.
        cycle(1'b1, 32'h3F800000, 32'h40400000);
        cycle(1'b1, 32'h41200000, 32'h3F000000);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        in_valid = 1'b1;
        A = 32'h40A00000;
        B = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        cycle(1'b1, 32'h42000000, 32'hC1000000);
        idle(4);

        // Randomized stream with sporadic gaps.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] base;
            base = 8'($urandom);
            cycle($urandom_range(0, 3) != 0, rand_fp(base), rand_fp(base));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
